// File: rtl/dm_access_unit.sv
// dm_access_unit: byte/half/word load-store initiator for a word-wide data memory.
// Define DM_ACCESS_BIG_ENDIAN_EN for big-endian lane placement (little-endian by default).
module dm_access_unit #(
  parameter int ADDR_W       = 32,
  parameter bit MISALIGN_ERR = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dmAddress,
  output logic              dmWriteEnabled,
  output logic [31:0]       dmWriteInput,
  input  logic [31:0]       dmReadResult
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_t;
  state_t r_state, w_next;
  logic r_we, r_uns, r_err;
  logic [1:0] r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_wdata, r_merge, r_rdata;
  logic w_accept, w_err, w_sub;
  logic [1:0] w_lo;
  logic [4:0] w_bsh, w_hsh;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_mask, w_ins;
  assign w_accept = req_valid && r_state == IDLE;
  assign w_err = req_size == 2'b11 || (MISALIGN_ERR && ((req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00)));
  // Force-align is harmless when misalignment is an error: those requests never access memory.
  assign w_lo = req_size == 2'b10 ? 2'b00 : req_size == 2'b01 ? {req_addr[1], 1'b0} : req_addr[1:0];
  assign w_sub = r_we && r_size != 2'b10;
`ifdef DM_ACCESS_BIG_ENDIAN_EN
  assign w_bsh = {~r_addr[1:0], 3'b000};
  assign w_hsh = {~r_addr[1], 4'b0000};
`else
  assign w_bsh = {r_addr[1:0], 3'b000};
  assign w_hsh = {r_addr[1], 4'b0000};
`endif
  assign w_byte = 8'(dmReadResult >> w_bsh);
  assign w_half = 16'(dmReadResult >> w_hsh);
  assign w_load = r_size == 2'b00 ? {{24{w_byte[7] & ~r_uns}}, w_byte} :
                  r_size == 2'b01 ? {{16{w_half[15] & ~r_uns}}, w_half} : dmReadResult;
  assign w_mask = r_size == 2'b00 ? 32'h0000_00FF << w_bsh : 32'h0000_FFFF << w_hsh;
  assign w_ins = r_size == 2'b00 ? {24'd0, r_wdata[7:0]} << w_bsh : {16'd0, r_wdata[15:0]} << w_hsh;
  assign resp_rdata = r_rdata;
  assign resp_err = r_err;
  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE ? (req_valid ? (w_err ? DONE : ACCESS) : IDLE) :
             r_state == ACCESS ? (w_sub ? MERGE_WR : DONE) :
             r_state == MERGE_WR ? DONE : (resp_ready ? IDLE : DONE);
  end
  // Reset gates the write strobe combinationally so an interrupted write never commits.
  always_comb begin
    req_ready = r_state == IDLE;
    resp_valid = r_state == DONE;
    dmAddress = (r_state == ACCESS || r_state == MERGE_WR) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    dmWriteEnabled = reset && ((r_state == ACCESS && r_we && r_size == 2'b10) || r_state == MERGE_WR);
    dmWriteInput = r_state == MERGE_WR ? (r_merge & ~w_mask) | (w_ins & w_mask) : r_wdata;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_we <= 1'b0;
      r_size <= 2'b00;
      r_uns <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_we <= req_we;
      r_size <= req_size;
      r_uns <= req_unsigned;
      r_addr <= {req_addr[ADDR_W-1:2], w_lo};
      r_wdata <= req_wdata;
      r_rdata <= '0;
      r_err <= w_err;
    end else if (r_state == ACCESS) begin
      if (!r_we) r_rdata <= w_load;
      if (w_sub) r_merge <= dmReadResult;
    end
  end
endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: directed table, reset corner case and random traffic against a byte-level memory model.
module tb_dm_access_unit;
`ifdef DM_ACCESS_BIG_ENDIAN_EN
  localparam bit BE = 1'b1;
  localparam logic [31:0] E_LB11 = 32'hFFFFFF99, E_LBU13 = 32'h000000BB, E_LH12 = 32'hFFFFAABB,
    E_LHU10 = 32'h00008899, E_LBU10 = 32'h00000088, E_SB12 = 32'h889955BB, E_SB13 = 32'h8899AA01;
`else
  localparam bit BE = 1'b0;
  localparam logic [31:0] E_LB11 = 32'hFFFFFFAA, E_LBU13 = 32'h00000088, E_LH12 = 32'hFFFF8899,
    E_LHU10 = 32'h0000AABB, E_LBU10 = 32'h000000BB, E_SB12 = 32'h8855AABB, E_SB13 = 32'h0199AABB;
`endif
  logic clock, reset, req_valid, req_ready, req_we, req_unsigned, resp_valid, resp_ready, resp_err;
  logic dmWriteEnabled;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, dmAddress, dmWriteInput, dmReadResult;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic we; logic [1:0] sz; logic uns; logic [31:0] a; logic [31:0] wd; int hold;
    logic [31:0] rd; logic er; int lat; int nw; logic [31:0] wv;
  } vec_t;
  vec_t tv [13];

  dm_access_unit dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmAddress(dmAddress), .dmWriteEnabled(dmWriteEnabled), .dmWriteInput(dmWriteInput),
    .dmReadResult(dmReadResult)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  assign dmReadResult = mem[dmAddress[7:2]];
  always_ff @(posedge clock) if (dmWriteEnabled) mem[dmAddress[7:2]] <= dmWriteInput;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int bpos(input int k);
    return BE ? 3 - k : k;
  endfunction

  // Memory viewed as four addressable bytes per word; lanes follow from byte order.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int nw, output logic [31:0] wv);
    int idx, nb, k0;
    logic [7:0] b [4];
    logic [31:0] v;
    idx = int'(a[7:2]);
    nb = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    k0 = int'(a[1:0]);
    er = sz == 2'b11 || (k0 % nb) != 0;
    rd = 0; nw = 0; wv = 0; v = 0;
    for (int k = 0; k < 4; k++) b[k] = ref_mem[idx][8*bpos(k) +: 8];
    if (er) lat = 1;
    else if (!we) begin
      for (int j = 0; j < nb; j++)
        v = BE ? ((v << 8) | 32'(b[k0+j])) : (v | (32'(b[k0+j]) << (8*j)));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rd = v; lat = 2;
    end else begin
      for (int j = 0; j < nb; j++) b[k0+j] = BE ? wd[8*(nb-1-j) +: 8] : wd[8*j +: 8];
      for (int k = 0; k < 4; k++) v[8*bpos(k) +: 8] = b[k];
      ref_mem[idx] = v; wv = v; nw = 1; lat = nb == 4 ? 2 : 3;
    end
  endtask

  task automatic txn(input vec_t v, input string nm);
    int lat, nw, wcyc;
    logic [31:0] wv, wa, rd;
    logic er;
    @(negedge clock);
    chk({nm, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({nm, "_idle_addr"}, dmAddress, 32'd0);
    req_valid = 1'b1; req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.a; req_wdata = v.wd;
    @(posedge clock);
    #1 req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom;
    req_wdata = $urandom;
    lat = 0; nw = 0; wv = 0; wa = 0; wcyc = 0;
    while (lat < 10) begin
      @(negedge clock);
      lat++;
      if (dmWriteEnabled) begin nw++; wv = dmWriteInput; wa = dmAddress; wcyc = lat; end
      if (resp_valid) break;
    end
    rd = resp_rdata; er = resp_err;
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_rdata"}, rd, v.rd);
    chk({nm, "_err"}, 32'(er), 32'(v.er));
    chk({nm, "_writes"}, nw, v.nw);
    if (v.nw > 0) begin
      chk({nm, "_wdata"}, wv, v.wv);
      chk({nm, "_waddr"}, wa, {v.a[31:2], 2'b00});
      chk({nm, "_wcycle"}, wcyc, v.lat - 1);
    end
    repeat (v.hold) begin
      @(negedge clock);
      chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_hold_rdata"}, resp_rdata, rd);
      chk({nm, "_hold_err"}, 32'(resp_err), 32'(er));
      chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [31:0] d_rd, d_wv;
    logic d_er;
    int d_lat, d_nw;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 0; req_wdata = 0; resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    tv[0]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, E_LB11, 1'b0, 2, 0, 32'h0};
    tv[1]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, E_LBU13, 1'b0, 2, 0, 32'h0};
    tv[2]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, E_LH12, 1'b0, 2, 0, 32'h0};
    tv[3]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0, E_LHU10, 1'b0, 2, 0, 32'h0};
    tv[4]  = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 0, E_LBU10, 1'b0, 2, 0, 32'h0};
    tv[5]  = '{1'b1, 2'b00, 1'b0, 32'h12, 32'h12345655, 0, 32'h0, 1'b0, 3, 1, E_SB12};
    tv[6]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 0, 32'h0, 1'b0, 2, 1, 32'h8899AABB};
    tv[7]  = '{1'b1, 2'b00, 1'b0, 32'h13, 32'h00000001, 0, 32'h0, 1'b0, 3, 1, E_SB13};
    tv[8]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF};
    tv[9]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0};
    tv[10] = '{1'b0, 2'b10, 1'b0, 32'h16, 32'h0, 0, 32'h0, 1'b1, 1, 0, 32'h0};
    tv[11] = '{1'b1, 2'b01, 1'b0, 32'h13, 32'hCAFEF00D, 2, 32'h0, 1'b1, 1, 0, 32'h0};
    tv[12] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h11223344, 0, 32'h0, 1'b1, 1, 0, 32'h0};
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_dm_we", 32'(dmWriteEnabled), 32'd0);
    chk("rst_dm_addr", dmAddress, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      model(tv[i].we, tv[i].sz, tv[i].uns, tv[i].a, tv[i].wd, d_rd, d_er, d_lat, d_nw, d_wv);
      txn(tv[i], $sformatf("vec%0d", i));
    end
    // Reset during the merge write of a halfword store must drop it without touching memory.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h00001234;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("mrst_access_we", 32'(dmWriteEnabled), 32'd0);
    @(negedge clock);
    chk("mrst_merge_we", 32'(dmWriteEnabled), 32'd1);
    reset = 1'b0;
    #1 chk("mrst_forced_we", 32'(dmWriteEnabled), 32'd0);
    @(negedge clock);
    chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mrst_mem", mem[4], ref_mem[4]);
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_req_ready", 32'(req_ready), 32'd1);
    chk("mrst_no_resp", 32'(resp_valid), 32'd0);
    for (int i = 0; i < 150; i++) begin
      v.we = 1'($urandom); v.sz = 2'($urandom); v.uns = 1'($urandom);
      v.a = $urandom; v.wd = $urandom; v.hold = $urandom_range(0, 2);
      model(v.we, v.sz, v.uns, v.a, v.wd, v.rd, v.er, v.lat, v.nw, v.wv);
      txn(v, $sformatf("rnd%0d", i));
    end
    @(negedge clock);
    for (int i = 0; i < 64; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
